// File: rtl/exmem_flag_if.sv
// EX-to-MEM stage bundle: the EX-side instruction fields and control going in,
// and the registered MEM-side fields and architectural flags coming out.
interface exmem_flag_if;
   logic        stall;
   logic        flush;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_result;
   logic        ex_ovfl;
   logic [3:0]  ex_rd;
   logic        ex_wr_en;

   logic        mem_valid;
   logic [15:0] mem_result;
   logic [3:0]  mem_rd;
   logic        mem_wr_en;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;

   modport master (
      output stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd, ex_wr_en,
      input  mem_valid, mem_result, mem_rd, mem_wr_en, flag_z, flag_v, flag_n
   );

   modport slave (
      input  stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd, ex_wr_en,
      output mem_valid, mem_result, mem_rd, mem_wr_en, flag_z, flag_v, flag_n
   );
endinterface

// File: rtl/exmem_flag_stage.sv
// EX/MEM pipeline register with architectural Z/V/N flag update.
// Priority on each edge: rst > stall > flush > advance; all outputs are registered.
module exmem_flag_stage (
   input  logic         clk,
   input  logic         rst,
   exmem_flag_if.slave  bus
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   logic        mem_valid_d,  mem_valid_q;
   logic [15:0] mem_result_d, mem_result_q;
   logic [3:0]  mem_rd_d,     mem_rd_q;
   logic        mem_wr_en_d,  mem_wr_en_q;
   logic        flag_z_d,     flag_z_q;
   logic        flag_v_d,     flag_v_q;
   logic        flag_n_d,     flag_n_q;

   logic        upd_nzv;
   logic        upd_z;

   always_comb begin
      upd_nzv = 1'b0;
      upd_z   = 1'b0;
      case (bus.ex_opcode)
         OP_ADD, OP_SUB: begin
            upd_nzv = 1'b1;
            upd_z   = 1'b1;
         end
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      mem_valid_d  = mem_valid_q;
      mem_result_d = mem_result_q;
      mem_rd_d     = mem_rd_q;
      mem_wr_en_d  = mem_wr_en_q;
      flag_z_d     = flag_z_q;
      flag_v_d     = flag_v_q;
      flag_n_d     = flag_n_q;

      if (bus.stall) begin
         // full hold; flush is ignored while stalled
      end else if (bus.flush) begin
         mem_valid_d = 1'b0;
         mem_wr_en_d = 1'b0;
      end else begin
         mem_valid_d  = bus.ex_valid;
         mem_result_d = bus.ex_result;
         mem_rd_d     = bus.ex_rd;
         mem_wr_en_d  = bus.ex_wr_en & bus.ex_valid;
         if (bus.ex_valid) begin
            if (upd_z) begin
               flag_z_d = (bus.ex_result == 16'h0000);
            end
            if (upd_nzv) begin
               flag_n_d = bus.ex_result[15];
               flag_v_d = bus.ex_ovfl;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid_q  <= 1'b0;
         mem_result_q <= 16'h0000;
         mem_rd_q     <= 4'h0;
         mem_wr_en_q  <= 1'b0;
         flag_z_q     <= 1'b0;
         flag_v_q     <= 1'b0;
         flag_n_q     <= 1'b0;
      end else begin
         mem_valid_q  <= mem_valid_d;
         mem_result_q <= mem_result_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_en_q  <= mem_wr_en_d;
         flag_z_q     <= flag_z_d;
         flag_v_q     <= flag_v_d;
         flag_n_q     <= flag_n_d;
      end
   end

   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_result = mem_result_q;
   assign bus.mem_rd     = mem_rd_q;
   assign bus.mem_wr_en  = mem_wr_en_q;
   assign bus.flag_z     = flag_z_q;
   assign bus.flag_v     = flag_v_q;
   assign bus.flag_n     = flag_n_q;

endmodule

// File: tb/tb_exmem_flag_stage.sv
// Directed and randomized bench for exmem_flag_stage against a behavioural
// model of the stage's latch/flag rules.
module tb_exmem_flag_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exmem_flag_if bus ();

   exmem_flag_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // model of the stage outputs
   logic        m_valid;
   logic [15:0] m_result;
   logic [3:0]  m_rd;
   logic        m_wr;
   logic        m_z, m_v, m_n;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mem_valid"},  {15'd0, bus.mem_valid}, {15'd0, m_valid});
      chk({tag, ".mem_result"}, bus.mem_result,          m_result);
      chk({tag, ".mem_rd"},     {12'd0, bus.mem_rd},    {12'd0, m_rd});
      chk({tag, ".mem_wr_en"},  {15'd0, bus.mem_wr_en}, {15'd0, m_wr});
      chk({tag, ".flag_z"},     {15'd0, bus.flag_z},    {15'd0, m_z});
      chk({tag, ".flag_v"},     {15'd0, bus.flag_v},    {15'd0, m_v});
      chk({tag, ".flag_n"},     {15'd0, bus.flag_n},    {15'd0, m_n});
      chk({tag, ".wr_implies_valid"}, {15'd0, bus.mem_wr_en & ~bus.mem_valid}, 16'd0);
   endtask

   // apply inputs, clock once, update model, check
   task automatic step(input string tag, input logic r, input logic st, input logic fl,
                       input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic [3:0] rd, input logic we);
      rst           = r;
      bus.stall     = st;
      bus.flush     = fl;
      bus.ex_valid  = v;
      bus.ex_opcode = op;
      bus.ex_result = res;
      bus.ex_ovfl   = ov;
      bus.ex_rd     = rd;
      bus.ex_wr_en  = we;
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_result = 0; m_rd = 0; m_wr = 0; m_z = 0; m_v = 0; m_n = 0;
      end else if (st) begin
      end else if (fl) begin
         m_valid = 0; m_wr = 0;
      end else begin
         m_valid  = v;
         m_result = res;
         m_rd     = rd;
         m_wr     = we && v;
         if (v) begin
            if (op == 4'd0 || op == 4'd1) begin
               m_z = (res == 0); m_n = res[15]; m_v = ov;
            end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
               m_z = (res == 0);
            end
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      m_valid = 0; m_result = 0; m_rd = 0; m_wr = 0; m_z = 0; m_v = 0; m_n = 0;
      bus.stall = 0; bus.flush = 0; bus.ex_valid = 0; bus.ex_opcode = 0;
      bus.ex_result = 0; bus.ex_ovfl = 0; bus.ex_rd = 0; bus.ex_wr_en = 0;

      // reset then idle
      step("rst0", 1, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0);
      step("rst1", 1, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0);
      chk("rst_valid", {15'd0, bus.mem_valid}, 16'd0);
      step("idle", 0, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0);

      // ADD with overflow
      step("add_ovfl", 0, 0, 0, 1, 4'b0000, 16'h8000, 1, 4'd3, 1);
      chk("add_n", {15'd0, bus.flag_n}, 16'd1);
      chk("add_v", {15'd0, bus.flag_v}, 16'd1);
      chk("add_z", {15'd0, bus.flag_z}, 16'd0);
      chk("add_res", bus.mem_result, 16'h8000);

      // SLL zero, then SRA all-ones
      step("sll_zero", 0, 0, 0, 1, 4'b0100, 16'h0000, 0, 4'd4, 1);
      chk("sll_z", {15'd0, bus.flag_z}, 16'd1);
      chk("sll_n_kept", {15'd0, bus.flag_n}, 16'd1);
      chk("sll_v_kept", {15'd0, bus.flag_v}, 16'd1);
      step("sra_ffff", 0, 0, 0, 1, 4'b0101, 16'hFFFF, 0, 4'd5, 0);
      chk("sra_z", {15'd0, bus.flag_z}, 16'd0);

      // stall with changing inputs, then release
      step("stall0", 0, 1, 0, 1, 4'b0000, 16'h0000, 0, 4'd9, 1);
      step("stall1", 0, 1, 0, 1, 4'b0001, 16'h1111, 1, 4'd10, 1);
      step("stall2", 0, 1, 1, 1, 4'b0010, 16'h2222, 0, 4'd11, 0);
      chk("stall_res", bus.mem_result, 16'hFFFF);
      step("unstall", 0, 0, 0, 1, 4'b0010, 16'h1234, 0, 4'd7, 1);
      chk("unstall_rd", {12'd0, bus.mem_rd}, 16'd7);

      // flush a valid zero-result SUB; stall+flush holds
      step("flush_sub", 0, 0, 1, 1, 4'b0001, 16'h0000, 0, 4'd2, 1);
      chk("flush_z", {15'd0, bus.flag_z}, 16'd0);
      step("add_pos", 0, 0, 0, 1, 4'b0000, 16'h0042, 0, 4'd1, 1);
      step("stall_flush", 0, 1, 1, 1, 4'b0001, 16'h0000, 1, 4'd6, 1);
      chk("sf_valid", {15'd0, bus.mem_valid}, 16'd1);

      // consecutive flag updates back to back
      step("b2b_sub", 0, 0, 0, 1, 4'b0001, 16'h0000, 0, 4'd8, 1);
      step("b2b_xor", 0, 0, 0, 1, 4'b0010, 16'h0001, 0, 4'd8, 1);
      step("b2b_add", 0, 0, 0, 1, 4'b0000, 16'hC000, 1, 4'd8, 1);
      step("bubble",  0, 0, 0, 0, 4'b0000, 16'h0000, 0, 4'd8, 1);

      // reset during stall
      step("stall_hold", 0, 1, 0, 1, 4'b0000, 16'h5555, 0, 4'd3, 1);
      step("rst_in_stall", 1, 1, 0, 1, 4'b0000, 16'h5555, 0, 4'd3, 1);
      chk("rst_stall_res", bus.mem_result, 16'h0000);
      step("post_rst", 0, 0, 0, 1, 4'b0110, 16'h0000, 0, 4'd12, 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic        r, st, fl, v, ov, we;
         logic [3:0]  op, rd;
         logic [15:0] res;
         r  = ($urandom_range(0, 40) == 0);
         st = ($urandom_range(0, 4) == 0);
         fl = ($urandom_range(0, 5) == 0);
         v  = ($urandom_range(0, 3) != 0);
         op = 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 15));
         ov = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       res = 16'h0000;
            1:       res = 16'h8000;
            2:       res = 16'hFFFF;
            default: res = 16'($urandom());
         endcase
         step("rand", r, st, fl, v, op, res, ov, rd, we);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
